bcd_scan_decoder: RTL and testbench
===================================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 Parameter N_DIGITS, default 4, number of scanned BCD digits (legal range 1..8).
REQ-002 Parameter DWELL, default 1000, clock cycles each digit is lit (minimum 1).
REQ-003 Parameter BLANK, default 50, clock cycles of inter-digit blanking (0 means no blanking gap).
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_n_rst  input  1  reset, synchronous, active-low.
REQ-006 i_bcd  input  4*N_DIGITS  packed BCD word; bits [3:0] are digit 0 (least significant).
REQ-007 i_load  input  1  active-high strobe; captures i_bcd into the shadow register.
REQ-008 i_en  input  1  active-high scan enable.
REQ-009 i_lzb  input  1  active-high leading-zero blanking enable.
REQ-010 o_n_dec  output  10  active-low one-hot decimal lines 0..9 (SN74145-style).
REQ-011 o_n_dig  output  N_DIGITS  active-low digit select, one-hot or all high.
REQ-012 o_frame  output  1  one-cycle pulse on completion of a full scan.
REQ-013 o_pending  output  1  high while shadow data awaits transfer to the active register.

Function
REQ-014 The FSM SHALL have states IDLE, SHOW and GAP; all outputs SHALL be registered.
REQ-015 IDLE: o_n_dec and o_n_dig all high; with i_en=1, next state is SHOW on digit 0, and the shadow-to-active transfer occurs.
REQ-016 SHOW: lasts exactly DWELL cycles; o_n_dig[k]=0 for current index k; o_n_dec[v]=0 for active digit value v in 0..9.
REQ-017 Digit values 10..15 SHALL drive o_n_dec all high while o_n_dig[k] is still asserted (74145 invalid-code behaviour).
REQ-018 GAP: lasts exactly BLANK cycles, with o_n_dec and o_n_dig all high; when BLANK=0, SHOW goes directly to SHOW of the next digit.
REQ-019 The digit index SHALL increment on leaving GAP (or SHOW when BLANK=0), wrapping from N_DIGITS-1 to 0.
REQ-020 On wrap, o_frame SHALL pulse high for exactly one cycle, aligned with the first SHOW cycle of digit 0.
REQ-021 On wrap, the shadow register SHALL transfer to the active register, and o_pending SHALL clear in the same cycle.
REQ-022 i_load=1 SHALL capture i_bcd into the shadow register and set o_pending on the next edge; a repeat load overwrites the shadow register.
REQ-023 i_load coinciding with a wrap SHALL transfer the new i_bcd directly to the active register, leaving o_pending low.
REQ-024 The active register SHALL never change mid-frame; this guarantees tear-free display.
REQ-025 With i_lzb=1, digits above the most significant nonzero digit SHALL hold o_n_dec all high during SHOW; digit 0 is never blanked.
REQ-026 The o_n_dig timing SHALL be unaffected by blanking.
REQ-027 i_en=0 in any state SHALL force IDLE on the next edge, with index 0, the timer cleared and o_frame low.
REQ-028 The dwell/blank timer SHALL be ceil(log2(max(DWELL,BLANK,2))) bits wide and SHALL reload on every state change.

Reset
REQ-029 i_n_rst=0 at a rising edge SHALL set: state IDLE, index 0, timer 0, shadow and active registers 0, o_n_dec=10'h3FF, o_n_dig all ones, o_frame=0, o_pending=0.
REQ-030 Reset SHALL take priority over i_load and i_en, and SHALL be effective mid-SHOW or mid-GAP.
REQ-031 After release with i_en=1, the first SHOW cycle of digit 0 SHALL appear one cycle later.

Verification (N_DIGITS=4, DWELL=4, BLANK=2)
REQ-032 Reset, then load 16'h1234 and set i_en=1 -> digit 0 shows o_n_dec=10'h3EF (4) for 4 cycles, followed by 2 all-high cycles; then 3, 2, 1; o_frame pulses at the wrap.
REQ-033 Load 16'h0056 mid-frame -> o_pending=1 until the wrap; the old value completes the frame; the next frame shows 6, 5, then two blank-value digits (value 0 displayed when i_lzb=0, all-high o_n_dec when i_lzb=1).
REQ-034 Digit value 4'hA -> o_n_dig asserted, o_n_dec=10'h3FF for 4 cycles.
REQ-035 Load strobe exactly on a wrap cycle with 16'h9999 -> 9 is shown immediately on digit 0; o_pending stays 0.
REQ-036 Drop i_en mid-GAP of digit 2, then restore after 3 cycles -> outputs all high the next cycle; scan restarts at digit 0.
REQ-037 Assert i_n_rst=0 mid-SHOW -> all outputs return to reset values on the next edge; shadow and active registers read 0.

Source files
------------

// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD display scanner: steps one lit digit at a time through a
// double-buffered BCD word and drives 74145-style active-low decimal lines.
module bcd_scan_decoder #(
  parameter int N_DIGITS = 4,
  parameter int DWELL    = 1000,
  parameter int BLANK    = 50
) (
  input  logic                  i_clk,
  input  logic                  i_n_rst,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic                  i_lzb,
  output logic [9:0]            o_n_dec,
  output logic [N_DIGITS-1:0]   o_n_dig,
  output logic                  o_frame,
  output logic                  o_pending
);

  localparam int MAXC = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                        : ((BLANK > 2) ? BLANK : 2);
  localparam int TW   = $clog2(MAXC);
  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] DWELL_M1 = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_M1 = TW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*N_DIGITS-1:0]   active_q, active_d;
  logic                    pending_q, pending_d;
  logic [9:0]              n_dec_q, n_dec_d;
  logic [N_DIGITS-1:0]     n_dig_q, n_dig_d;
  logic                    frame_q, frame_d;
  logic                    wrap, xfer;

  // State and datapath registers; outputs are registered from next-state
  // values so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      n_dec_q   <= '1;
      n_dig_q   <= '1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      n_dec_q   <= n_dec_d;
      n_dig_q   <= n_dig_d;
      frame_q   <= frame_d;
    end
  end

  // Next-state: timer counts down and reloads on every state change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    wrap    = 1'b0;
    xfer    = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
      idx_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          tmr_d   = DWELL_M1;
          xfer    = 1'b1;
        end
        SHOW, GAP: begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
          end else if (state_q == SHOW && BLANK > 0) begin
            state_d = GAP;
            tmr_d   = BLANK_M1;
          end else begin
            state_d = SHOW;
            tmr_d   = DWELL_M1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
              xfer  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: the active word only changes at a frame boundary, and a
  // load landing on that boundary bypasses the shadow straight to active.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (i_load) begin
      shadow_d  = i_bcd;
      pending_d = 1'b1;
    end
    if (xfer) begin
      active_d  = i_load ? i_bcd : shadow_q;
      pending_d = 1'b0;
    end
  end

  // Output decode from next-state values.
  logic [3:0]    val;
  logic [IW-1:0] msnz;
  logic          lz_blank;

  always_comb begin
    n_dec_d  = '1;
    n_dig_d  = '1;
    frame_d  = wrap;
    val      = 4'hF;
    msnz     = '0;
    lz_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (active_d[4*k +: 4] != 4'h0) msnz = IW'(k);
    end
    if (state_d == SHOW) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (idx_d == IW'(k)) begin
          n_dig_d[k] = 1'b0;
          val        = active_d[4*k +: 4];
        end
      end
      lz_blank = i_lzb && (idx_d > msnz);
      // Codes 10..15 fall through with every decimal line high.
      if (!lz_blank) begin
        for (int j = 0; j < 10; j++) begin
          if (val == 4'(j)) n_dec_d[j] = 1'b0;
        end
      end
    end
  end

  assign o_n_dec   = n_dec_q;
  assign o_n_dig   = n_dig_q;
  assign o_frame   = frame_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed scoreboard bench for bcd_scan_decoder (4 digits, dwell 4, blank 2).
module tb_bcd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n, ld, en, lzb;
  logic [15:0] bcd;
  logic [9:0]  o_n_dec;
  logic [3:0]  o_n_dig;
  logic        o_frame, o_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [9:0] dec;
    logic [3:0] dig;
    logic       frm;
    logic       pnd;
  } exp_t;

  exp_t q[$];

  bcd_scan_decoder #(.N_DIGITS(4), .DWELL(4), .BLANK(2)) dut (
    .i_clk    (clk),
    .i_n_rst  (rst_n),
    .i_bcd    (bcd),
    .i_load   (ld),
    .i_en     (en),
    .i_lzb    (lzb),
    .o_n_dec  (o_n_dec),
    .o_n_dig  (o_n_dig),
    .o_frame  (o_frame),
    .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dec_of(input int v);
    logic [9:0] t;
    t = '1;
    if (v < 10) t[v] = 1'b0;
    return t;
  endfunction

  function automatic logic [3:0] dig_of(input int k);
    logic [3:0] t;
    t = '1;
    t[k] = 1'b0;
    return t;
  endfunction

  // One clock: the load strobe lasts a single edge; expected outputs after
  // that edge go to the scoreboard.
  task automatic tick(input logic [9:0] d, input logic [3:0] g,
                      input logic f, input logic p);
    exp_t e;
    @(posedge clk);
    #1;
    ld = 1'b0;
    e.dec = d; e.dig = g; e.frm = f; e.pnd = p;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic show(input int k, input int v, input logic f, input logic p);
    for (int i = 0; i < 4; i++) tick(dec_of(v), dig_of(k), (i == 0) ? f : 1'b0, p);
  endtask

  task automatic gap(input logic p);
    repeat (2) tick(10'h3FF, 4'hF, 1'b0, p);
  endtask

  task automatic idle(input logic p);
    tick(10'h3FF, 4'hF, 1'b0, p);
  endtask

  // Monitor: pops one expectation per sampled cycle, away from the edge.
  initial begin : monitor
    exp_t e;
    exp_t got;
    int   step;
    step = 0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = {o_n_dec, o_n_dig, o_frame, o_pending};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL step%0d: got dec=%h dig=%h frame=%b pend=%b, want dec=%h dig=%h frame=%b pend=%b",
                   step, got.dec, got.dig, got.frm, got.pnd, e.dec, e.dig, e.frm, e.pnd);
        end
        step++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; lzb = 1'b0; bcd = '0;
    @(negedge clk);
    idle(0); idle(0);

    // load while idle, then enable: first frame of 1234
    rst_n = 1'b1; ld = 1'b1; bcd = 16'h1234;
    idle(1);
    en = 1'b1;
    show(0, 4, 0, 0); gap(0); show(1, 3, 0, 0); gap(0);
    show(2, 2, 0, 0); gap(0); show(3, 1, 0, 0); gap(0);

    // second frame: mid-frame load stays pending, old value completes
    show(0, 4, 1, 0);
    ld = 1'b1; bcd = 16'h0056;
    gap(1); show(1, 3, 0, 1); gap(1);
    show(2, 2, 0, 1); gap(1); show(3, 1, 0, 1); gap(1);

    // 0056 without leading-zero blanking
    show(0, 6, 1, 0); gap(0); show(1, 5, 0, 0); gap(0);
    show(2, 0, 0, 0); gap(0); show(3, 0, 0, 0); gap(0);
    lzb = 1'b1;

    // 0056 with leading-zero blanking; load lands on the wrap edge
    show(0, 6, 1, 0); gap(0); show(1, 5, 0, 0); gap(0);
    show(2, 15, 0, 0); gap(0); show(3, 15, 0, 0); gap(0);
    ld = 1'b1; bcd = 16'h9999;

    // 9999 shows immediately; drop enable mid-gap of digit 2
    show(0, 9, 1, 0); gap(0); show(1, 9, 0, 0); gap(0); show(2, 9, 0, 0);
    idle(0);
    en = 1'b0; ld = 1'b1; bcd = 16'h00A0;
    idle(1); idle(1); idle(1);
    en = 1'b1;

    // restart at digit 0 without a frame pulse; invalid code A on digit 1
    show(0, 0, 0, 0); gap(0); show(1, 10, 0, 0); gap(0);
    tick(10'h3FF, dig_of(2), 1'b0, 1'b0);
    tick(10'h3FF, dig_of(2), 1'b0, 1'b0);

    // reset mid-SHOW beats a simultaneous load
    rst_n = 1'b0; ld = 1'b1; bcd = 16'hFFFF;
    idle(0);
    rst_n = 1'b1;
    show(0, 0, 0, 0);
    en = 1'b0;
    idle(0);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
